// File: rtl/sram_output_drain.sv
// Streams a programmed address range out of a 1-cycle-latency single-port SRAM through a 4-entry skid FIFO.
// Build option SRAM_DRAIN_CLEAR_EN: every read also writes zero back (read-and-clear).
module sram_output_drain #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sram_cen_n_o,
    output logic                  sram_wen_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_data_in_o,
    input  logic [DATA_WIDTH-1:0] sram_data_out_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o
);

    // state | meaning
    // IDLE  | waiting for start, no SRAM access
    // RUN   | issuing reads and streaming words until out_left reaches zero
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    state_t                state_q, state_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
    logic [ADDR_WIDTH:0]   out_left_q, out_left_d;
    logic [1:0]            inflight_q, inflight_d;
    logic                  rd_pend_q;

    logic [DATA_WIDTH-1:0] fifo_mem_q [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            fifo_count_q;

    logic [3:0]            credit_used;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  fifo_nonempty;

    // Credit covers both queued words and reads whose data has not landed yet.
    assign credit_used   = {1'b0, fifo_count_q} + {2'b00, inflight_q};
    assign issue         = (state_q == ST_RUN) && (issue_left_q != '0) && (credit_used < 4'd4);
    assign push          = rd_pend_q;
    assign fifo_nonempty = (fifo_count_q != 3'd0);
    assign pop           = fifo_nonempty && m_ready_i;
    assign inflight_d    = inflight_q + {1'b0, issue} - {1'b0, push};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            done_q       <= 1'b0;
            rd_addr_q    <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            rd_addr_q    <= rd_addr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        rd_addr_d    = rd_addr_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (length_i != '0) begin
                        state_d      = ST_RUN;
                        rd_addr_d    = base_addr_i;
                        issue_left_d = length_i;
                        out_left_d   = length_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    rd_addr_d    = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
                    issue_left_d = issue_left_q - CNT_ONE;
                end
                if (pop) begin
                    out_left_d = out_left_q - CNT_ONE;
                    if (out_left_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q == ST_RUN);
        done_o       = done_q;
        sram_cen_n_o = ~issue;
        sram_addr_o  = issue ? rd_addr_q : '0;
`ifdef SRAM_DRAIN_CLEAR_EN
        sram_wen_o   = issue;
`else
        sram_wen_o   = 1'b0;
`endif
        sram_data_in_o = '0;
        m_valid_o    = fifo_nonempty;
        m_data_o     = fifo_mem_q[rd_ptr_q];
        m_last_o     = fifo_nonempty && (out_left_q == CNT_ONE);
    end

    // Read data is valid the cycle after the issuing edge, so it is captured one edge later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_pend_q    <= 1'b0;
            inflight_q   <= 2'd0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_count_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            rd_pend_q  <= issue;
            inflight_q <= inflight_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= sram_data_out_i;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            fifo_count_q <= fifo_count_q + {2'b00, push} - {2'b00, pop};
        end
    end

endmodule
